// File: rtl/pusch_sym_buf_ctrl_if.sv
// Handshake/bus bundle between the CPRI unpack stage, the symbol-RAM writer and the
// symbol consumer; the controller side uses the slave modport.
interface pusch_sym_buf_ctrl_if;
  logic        i_slot_sync;
  logic        i_iq_vld;
  logic [10:0] i_iq_addr;
  logic        i_rd_done;
  logic        o_wr_en;
  logic        o_wr_bank;
  logic [10:0] o_wr_addr;
  logic        o_rd_valid;
  logic        o_rd_bank;
  logic [3:0]  o_rd_sym;
  logic        o_sym1_done;
  logic        o_overflow;
  logic        o_addr_err;

  modport master (
    output i_slot_sync, i_iq_vld, i_iq_addr, i_rd_done,
    input  o_wr_en, o_wr_bank, o_wr_addr, o_rd_valid, o_rd_bank, o_rd_sym,
           o_sym1_done, o_overflow, o_addr_err
  );

  modport slave (
    input  i_slot_sync, i_iq_vld, i_iq_addr, i_rd_done,
    output o_wr_en, o_wr_bank, o_wr_addr, o_rd_valid, o_rd_bank, o_rd_sym,
           o_sym1_done, o_overflow, o_addr_err
  );
endinterface

// File: rtl/pusch_sym_buf_ctrl.sv
// Ping-pong PUSCH symbol buffer controller: write strobes 1 cycle after each IQ word, read offer is combinational on bank state.
// No backpressure on the IQ stream: a symbol arriving with no free bank is dropped and flagged.
module pusch_sym_buf_ctrl #(
  parameter int NRE  = 1584,
  parameter int NSYM = 14
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  pusch_sym_buf_ctrl_if.slave  bus
);

  localparam logic [1:0]  BANK_FREE = 2'd0;
  localparam logic [1:0]  BANK_FILL = 2'd1;
  localparam logic [1:0]  BANK_FULL = 2'd2;
  localparam logic [10:0] LAST_ADDR = 11'(NRE - 1);
  localparam logic [3:0]  LAST_SYM  = 4'(NSYM - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } wr_state_t;

  wr_state_t        state, state_nxt, cur_st;
  logic [1:0][1:0]  bank_st, bank_nxt;
  logic [1:0][3:0]  tag, tag_nxt;
  logic             wb, wb_nxt;
  logic             rb, rb_nxt;
  logic [3:0]       sym_idx, sym_nxt, sym_adv;
  logic [10:0]      exp_addr, exp_nxt;
  logic             wr_en_q, wr_en_nxt;
  logic             wr_bank_q, wr_bank_nxt;
  logic [10:0]      wr_addr_q, wr_addr_nxt;
  logic             sym1_q, sym1_nxt;
  logic             ovf_q, ovf_nxt;
  logic             aerr_q, aerr_nxt;
  logic             addr_ok, addr_last;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      bank_st   <= '0;
      tag       <= '0;
      wb        <= 1'b0;
      rb        <= 1'b0;
      sym_idx   <= 4'd0;
      exp_addr  <= 11'd0;
      wr_en_q   <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_addr_q <= 11'd0;
      sym1_q    <= 1'b0;
      ovf_q     <= 1'b0;
      aerr_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      bank_st   <= bank_nxt;
      tag       <= tag_nxt;
      wb        <= wb_nxt;
      rb        <= rb_nxt;
      sym_idx   <= sym_nxt;
      exp_addr  <= exp_nxt;
      wr_en_q   <= wr_en_nxt;
      wr_bank_q <= wr_bank_nxt;
      wr_addr_q <= wr_addr_nxt;
      sym1_q    <= sym1_nxt;
      ovf_q     <= ovf_nxt;
      aerr_q    <= aerr_nxt;
    end
  end

  assign addr_ok   = (bus.i_iq_addr == exp_addr);
  assign addr_last = (bus.i_iq_addr == LAST_ADDR);
  assign sym_adv   = (sym_idx == LAST_SYM) ? 4'd0 : sym_idx + 4'd1;

  always_comb begin
    state_nxt   = state;
    bank_nxt    = bank_st;
    tag_nxt     = tag;
    wb_nxt      = wb;
    rb_nxt      = rb;
    sym_nxt     = sym_idx;
    exp_nxt     = exp_addr;
    wr_en_nxt   = 1'b0;
    wr_bank_nxt = wr_bank_q;
    wr_addr_nxt = wr_addr_q;
    sym1_nxt    = 1'b0;
    ovf_nxt     = ovf_q;
    aerr_nxt    = aerr_q;
    cur_st      = state;

    // Slot sync acts before the current word so a coincident addr==0 starts symbol 0.
    if (bus.i_slot_sync) begin
      if (state == ST_WRITE) begin
        bank_nxt[wb] = BANK_FREE;
      end
      cur_st    = ST_IDLE;
      state_nxt = ST_IDLE;
      sym_nxt   = 4'd0;
      exp_nxt   = 11'd0;
    end

    case (cur_st)
      ST_IDLE: begin
        if (bus.i_iq_vld && (bus.i_iq_addr == 11'd0)) begin
          exp_nxt = 11'd1;
          if (bank_nxt[wb] == BANK_FREE) begin
            state_nxt    = ST_WRITE;
            bank_nxt[wb] = BANK_FILL;
            wr_en_nxt    = 1'b1;
            wr_bank_nxt  = wb;
            wr_addr_nxt  = bus.i_iq_addr;
          end else begin
            state_nxt = ST_DROP;
            ovf_nxt   = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        if (bus.i_iq_vld) begin
          if (!addr_ok) begin
            aerr_nxt     = 1'b1;
            bank_nxt[wb] = BANK_FREE;
            state_nxt    = ST_IDLE;
            exp_nxt      = 11'd0;
          end else begin
            wr_en_nxt   = 1'b1;
            wr_bank_nxt = wb;
            wr_addr_nxt = bus.i_iq_addr;
            if (addr_last) begin
              bank_nxt[wb] = BANK_FULL;
              tag_nxt[wb]  = sym_idx;
              wb_nxt       = ~wb;
              state_nxt    = ST_IDLE;
              exp_nxt      = 11'd0;
              sym_nxt      = sym_adv;
              sym1_nxt     = (sym_idx == 4'd1);
            end else begin
              exp_nxt = exp_addr + 11'd1;
            end
          end
        end
      end

      ST_DROP: begin
        if (bus.i_iq_vld) begin
          if (!addr_ok) begin
            aerr_nxt  = 1'b1;
            state_nxt = ST_IDLE;
            exp_nxt   = 11'd0;
          end else if (addr_last) begin
            state_nxt = ST_IDLE;
            exp_nxt   = 11'd0;
            sym_nxt   = sym_adv;
          end else begin
            exp_nxt = exp_addr + 11'd1;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        exp_nxt   = 11'd0;
      end
    endcase

    // The offered bank is FULL, so it can never be the bank the writer is touching.
    if (bus.i_rd_done && (bank_st[rb] == BANK_FULL)) begin
      bank_nxt[rb] = BANK_FREE;
      rb_nxt       = ~rb;
    end
  end

  always_comb begin
    bus.o_wr_en     = wr_en_q;
    bus.o_wr_bank   = wr_bank_q;
    bus.o_wr_addr   = wr_addr_q;
    bus.o_rd_valid  = (bank_st[rb] == BANK_FULL);
    bus.o_rd_bank   = rb;
    bus.o_rd_sym    = tag[rb];
    bus.o_sym1_done = sym1_q;
    bus.o_overflow  = ovf_q;
    bus.o_addr_err  = aerr_q;
  end

endmodule

// File: tb/tb_pusch_sym_buf_ctrl.sv
// Bench for pusch_sym_buf_ctrl: symbol-level queue model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_pusch_sym_buf_ctrl;
  localparam int NRE  = 1584;
  localparam int NSYM = 14;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;
  logic chk_en  = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wr_seen = 0;
  int   sym1_seen = 0;

  pusch_sym_buf_ctrl_if bus ();

  pusch_sym_buf_ctrl #(.NRE(NRE), .NSYM(NSYM)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Symbol-level model: full banks form a FIFO of tags; bank numbers follow
  // from how many symbols have been completed and consumed.
  int          m_mode;   // 0 idle, 1 writing, 2 dropping
  int          m_exp, m_sym, m_wr_cnt, m_rd_cnt, m_a;
  int          m_q[$];
  bit          m_fire;
  logic        e_wr_en, e_wr_bank, e_sym1, e_ovf, e_aerr;
  logic [10:0] e_wr_addr;

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      m_mode = 0; m_exp = 0; m_sym = 0; m_wr_cnt = 0; m_rd_cnt = 0;
      m_q.delete();
      e_wr_en = 0; e_wr_bank = 0; e_wr_addr = '0; e_sym1 = 0; e_ovf = 0; e_aerr = 0;
    end else begin
      m_fire  = bus.i_rd_done && (m_q.size() > 0);
      m_a     = int'(bus.i_iq_addr);
      e_wr_en = 0;
      e_sym1  = 0;
      if (bus.i_slot_sync) begin
        m_mode = 0;
        m_sym  = 0;
      end
      if (bus.i_iq_vld) begin
        if (m_mode == 0) begin
          if (m_a == 0) begin
            m_exp = 1;
            if (m_q.size() < 2) begin
              m_mode = 1;
              e_wr_en = 1; e_wr_bank = m_wr_cnt[0]; e_wr_addr = 11'(m_a);
            end else begin
              m_mode = 2;
              e_ovf  = 1;
            end
          end
        end else if (m_a != m_exp) begin
          e_aerr = 1;
          m_mode = 0;
        end else begin
          if (m_mode == 1) begin
            e_wr_en = 1; e_wr_bank = m_wr_cnt[0]; e_wr_addr = 11'(m_a);
          end
          if (m_a == NRE - 1) begin
            if (m_mode == 1) begin
              m_q.push_back(m_sym);
              m_wr_cnt++;
              if (m_sym == 1) e_sym1 = 1;
            end
            m_sym  = (m_sym + 1) % NSYM;
            m_mode = 0;
          end else begin
            m_exp++;
          end
        end
      end
      if (m_fire) begin
        void'(m_q.pop_front());
        m_rd_cnt++;
      end
    end
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      check("wr_en", 32'(bus.o_wr_en), 32'(e_wr_en));
      if (e_wr_en) begin
        check("wr_bank", 32'(bus.o_wr_bank), 32'(e_wr_bank));
        check("wr_addr", 32'(bus.o_wr_addr), 32'(e_wr_addr));
      end
      check("rd_valid", 32'(bus.o_rd_valid), 32'(m_q.size() > 0));
      check("rd_bank", 32'(bus.o_rd_bank), 32'(m_rd_cnt % 2));
      if (m_q.size() > 0) check("rd_sym", 32'(bus.o_rd_sym), 32'(m_q[0]));
      check("sym1_done", 32'(bus.o_sym1_done), 32'(e_sym1));
      check("overflow", 32'(bus.o_overflow), 32'(e_ovf));
      check("addr_err", 32'(bus.o_addr_err), 32'(e_aerr));
    end
    if (!i_reset) begin
      if (bus.o_wr_en === 1'b1) wr_seen++;
      if (bus.o_sym1_done === 1'b1) sym1_seen++;
    end
  end

  task automatic cyc(input logic s, input logic v, input int a, input logic d);
    bus.i_slot_sync = s;
    bus.i_iq_vld    = v;
    bus.i_iq_addr   = 11'(a);
    bus.i_rd_done   = d;
    @(posedge i_clk);
    #1;
    bus.i_slot_sync = 1'b0;
    bus.i_iq_vld    = 1'b0;
    bus.i_iq_addr   = 11'd0;
    bus.i_rd_done   = 1'b0;
  endtask

  task automatic send_sym(input logic sync_first, input logic done_last);
    for (int i = 0; i < NRE; i++) cyc(sync_first && (i == 0), 1'b1, i, done_last && (i == NRE - 1));
  endtask

  task automatic check_all_zero(input string tag_s);
    check({tag_s, "_wr_en"},    32'(bus.o_wr_en), 0);
    check({tag_s, "_wr_addr"},  32'(bus.o_wr_addr), 0);
    check({tag_s, "_rd_valid"}, 32'(bus.o_rd_valid), 0);
    check({tag_s, "_rd_bank"},  32'(bus.o_rd_bank), 0);
    check({tag_s, "_rd_sym"},   32'(bus.o_rd_sym), 0);
    check({tag_s, "_overflow"}, 32'(bus.o_overflow), 0);
    check({tag_s, "_addr_err"}, 32'(bus.o_addr_err), 0);
  endtask

  int w0, s0;

  initial begin
    bus.i_slot_sync = 1'b0;
    bus.i_iq_vld    = 1'b0;
    bus.i_iq_addr   = 11'd0;
    bus.i_rd_done   = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk_en = 1'b1;
    check_all_zero("reset");
    i_reset = 1'b0;
    cyc(0, 0, 0, 0);

    // Two back-to-back symbols fill both banks.
    s0 = sym1_seen;
    send_sym(0, 0);
    send_sym(0, 0);
    check("t1_sym1_pulse", 32'(bus.o_sym1_done), 1);
    check("t1_last_bank", 32'(bus.o_wr_bank), 1);
    check("t1_last_addr", 32'(bus.o_wr_addr), 1583);
    check("t1_rd_valid", 32'(bus.o_rd_valid), 1);
    check("t1_rd_bank", 32'(bus.o_rd_bank), 0);
    check("t1_rd_sym", 32'(bus.o_rd_sym), 0);
    cyc(0, 0, 0, 0);
    check("t1_sym1_once", 32'(sym1_seen - s0), 1);
    check("t1_sym1_low", 32'(bus.o_sym1_done), 0);

    // Third symbol dropped; consumer frees bank0, fourth lands there with tag 3.
    w0 = wr_seen;
    send_sym(0, 0);
    cyc(0, 0, 0, 0);
    check("t2_no_write", 32'(wr_seen - w0), 0);
    check("t2_overflow", 32'(bus.o_overflow), 1);
    cyc(0, 0, 0, 1);
    check("t2_rd_bank1", 32'(bus.o_rd_bank), 1);
    check("t2_rd_sym1", 32'(bus.o_rd_sym), 1);
    send_sym(0, 0);
    check("t2_sym4_bank", 32'(bus.o_wr_bank), 0);
    cyc(0, 0, 0, 1);
    check("t2_rd_bank0", 32'(bus.o_rd_bank), 0);
    check("t2_rd_sym3", 32'(bus.o_rd_sym), 3);
    cyc(0, 0, 0, 1);
    check("t2_rd_empty", 32'(bus.o_rd_valid), 0);
    cyc(0, 0, 0, 1);
    check("t2_done_ignored", 32'(bus.o_rd_bank), 1);

    // Idle words with nonzero address are ignored silently.
    w0 = wr_seen;
    cyc(0, 1, 5, 0);
    cyc(0, 1, 6, 0);
    cyc(0, 0, 0, 0);
    check("t3_idle_no_err", 32'(bus.o_addr_err), 0);
    check("t3_idle_no_wr", 32'(wr_seen - w0), 0);

    // Address gap aborts; the retry keeps the same tag and bank.
    w0 = wr_seen;
    for (int i = 0; i < 100; i++) cyc(0, 1, i, 0);
    cyc(0, 1, 101, 0);
    check("t3_addr_err", 32'(bus.o_addr_err), 1);
    check("t3_partial_wr", 32'(wr_seen - w0), 100);
    check("t3_not_offered", 32'(bus.o_rd_valid), 0);
    send_sym(0, 0);
    check("t3_retry_bank", 32'(bus.o_wr_bank), 1);
    check("t3_rd_sym4", 32'(bus.o_rd_sym), 4);
    cyc(0, 0, 0, 1);

    // Slot sync mid symbol 5 frees the bank and restarts at tag 0.
    for (int i = 0; i < 700; i++) cyc(0, 1, i, 0);
    cyc(1, 1, 700, 0);
    check("t4_sync_no_wr", 32'(bus.o_wr_en), 0);
    cyc(0, 1, 701, 0);
    send_sym(0, 0);
    check("t4_bank", 32'(bus.o_wr_bank), 0);
    check("t4_rd_sym0", 32'(bus.o_rd_sym), 0);
    check("t4_ovf_kept", 32'(bus.o_overflow), 1);
    check("t4_aerr_kept", 32'(bus.o_addr_err), 1);

    // Consumer release coincides with the last word into the other bank.
    for (int i = 0; i < NRE; i++) cyc(0, 1, i, i == NRE - 1);
    check("t5_rd_bank", 32'(bus.o_rd_bank), 1);
    check("t5_rd_valid", 32'(bus.o_rd_valid), 1);
    check("t5_rd_sym", 32'(bus.o_rd_sym), 1);
    check("t5_sym1", 32'(bus.o_sym1_done), 1);
    cyc(0, 0, 0, 1);
    check("t5_empty", 32'(bus.o_rd_valid), 0);

    // A full slot plus one, consumed immediately; sync on the first word.
    for (int k = 0; k <= NSYM; k++) begin
      w0 = wr_seen;
      send_sym(k == 0, 0);
      check("t7_tag", 32'(bus.o_rd_sym), 32'(k % NSYM));
      cyc(0, 0, 0, 1);
      check("t7_full_write", 32'(wr_seen - w0), NRE);
    end

    // Reset mid symbol discards it and clears the sticky flags.
    for (int i = 0; i < 500; i++) cyc(0, 1, i, 0);
    i_reset = 1'b1;
    cyc(0, 0, 0, 0);
    check_all_zero("midrst");
    i_reset = 1'b0;
    cyc(0, 0, 0, 0);
    send_sym(0, 0);
    check("t8_bank", 32'(bus.o_wr_bank), 0);
    check("t8_rd_valid", 32'(bus.o_rd_valid), 1);
    check("t8_rd_sym", 32'(bus.o_rd_sym), 0);
    check("t8_ovf", 32'(bus.o_overflow), 0);
    check("t8_aerr", 32'(bus.o_addr_err), 0);
    cyc(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pusch_sym_buf_ctrl.md
PUSCH_SYM_BUF_CTRL -- requirements
Module: pusch_sym_buf_ctrl

Interface
REQ-001 SHALL have parameter NRE, default 1584, meaning unpacked IQ words per symbol (all ANT antennas in parallel).
REQ-002 SHALL have parameter NSYM, default 14, meaning symbols per slot.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port i_reset, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port i_slot_sync, input, 1 bit: slot start pulse that resynchronises the symbol index.
REQ-006 SHALL have port i_iq_vld, input, 1 bit: unpacked IQ word valid, from the CPRI unpack stage.
REQ-007 SHALL have port i_iq_addr, input, 11 bits: RE index of the current word, 0..NRE-1.
REQ-008 SHALL have port i_rd_done, input, 1 bit: consumer pulse that releases the bank currently offered.
REQ-009 SHALL have port o_wr_en, output, 1 bit: symbol-RAM write enable.
REQ-010 SHALL have port o_wr_bank, output, 1 bit: ping-pong bank being written.
REQ-011 SHALL have port o_wr_addr, output, 11 bits: symbol-RAM write address.
REQ-012 SHALL have port o_rd_valid, output, 1 bit: a full bank is offered to the consumer.
REQ-013 SHALL have port o_rd_bank, output, 1 bit: bank offered to the consumer.
REQ-014 SHALL have port o_rd_sym, output, 4 bits: symbol index held in the offered bank.
REQ-015 SHALL have port o_sym1_done, output, 1 bit: one-cycle pulse when symbol 1 is fully written.
REQ-016 SHALL have port o_overflow, output, 1 bit: sticky flag, a symbol was dropped.
REQ-017 SHALL have port o_addr_err, output, 1 bit: sticky flag, an RE address discontinuity was seen.

Function
REQ-018 SHALL keep a 2-bit state per bank: FREE=0, FILL=1, FULL=2.
REQ-019 SHALL run the writer FSM with states IDLE, WRITE and DROP, plus an expected-address counter exp_addr.
REQ-020 IDLE: on i_iq_vld with i_iq_addr==0, SHALL go to WRITE if bank wb is FREE (bank wb becomes FILL), otherwise go to DROP and set o_overflow.
REQ-021 WRITE: SHALL register each valid word so that o_wr_en=1, o_wr_addr=i_iq_addr and o_wr_bank=wb, with latency exactly 1 cycle.
REQ-022 DROP: SHALL keep o_wr_en at 0 for the whole symbol.
REQ-023 On i_iq_vld with i_iq_addr==NRE-1 in WRITE, SHALL set bank wb to FULL, store the tag sym_idx for it, toggle wb, and return to IDLE.
REQ-024 On i_iq_vld with i_iq_addr==NRE-1 in DROP, SHALL return to IDLE without toggling wb.
REQ-025 At every symbol end (written or dropped), SHALL advance sym_idx modulo NSYM (13 wraps to 0).
REQ-026 SHALL pulse o_sym1_done for one cycle, one cycle after the end of a written symbol whose sym_idx==1; no pulse if that symbol was dropped.
REQ-027 SHALL compare every valid word against exp_addr; on mismatch, set o_addr_err, abort the symbol (bank wb returns to FREE, FSM goes to IDLE, sym_idx unchanged), and resume at the next addr==0.
REQ-028 In IDLE, a valid word with addr!=0 SHALL be ignored without setting o_addr_err.
REQ-029 Reader: o_rd_valid SHALL equal (bank rb == FULL); o_rd_bank=rb; o_rd_sym=tag[rb].
REQ-030 i_rd_done while o_rd_valid==1 SHALL set bank rb to FREE and toggle rb, so o_rd_valid updates on the next cycle.
REQ-031 i_rd_done while o_rd_valid==0 SHALL be ignored.
REQ-032 When a write completion and an i_rd_done fall in the same cycle, SHALL apply both updates.
REQ-033 A bank freed by i_rd_done SHALL be usable by a symbol starting in the following cycle.
REQ-034 i_slot_sync SHALL set sym_idx=0 and abort any WRITE/DROP (bank wb FILL becomes FREE, FSM goes to IDLE).
REQ-035 i_slot_sync SHALL leave FULL banks, rb and the sticky flags unchanged.
REQ-036 i_slot_sync coincident with a valid addr==0 word SHALL take effect first, then start the symbol with sym_idx 0.
REQ-037 The sticky flags SHALL clear only on reset.

Reset
REQ-038 While i_reset=1, asynchronously: both banks FREE, wb=rb=0, FSM in IDLE, sym_idx=0, exp_addr=0, and all outputs 0 (o_wr_en, o_wr_bank, o_wr_addr, o_rd_valid, o_rd_bank, o_rd_sym, o_sym1_done, o_overflow, o_addr_err).
REQ-039 Reset asserted mid-symbol SHALL discard the partial symbol; the first symbol after release SHALL be written to bank 0 with tag 0.

Verification
REQ-040 Two full symbols of 1584 contiguous words with no i_rd_done -> bank0 tag 0, bank1 tag 1; o_rd_valid=1, o_rd_bank=0; one o_sym1_done pulse one cycle after word 1583 of the second symbol.
REQ-041 A third symbol with both banks FULL -> o_wr_en stays 0 throughout, o_overflow=1, sym_idx=3; i_rd_done then frees bank0 and the fourth symbol is written to bank0 with tag 3.
REQ-042 Addresses 0..99 then 101 -> o_addr_err=1, bank returns to FREE; the next 0..1583 burst is written with the same tag.
REQ-043 i_slot_sync at word 700 of symbol 5 -> bank FILL becomes FREE, sym_idx=0; the next symbol is tagged 0.
REQ-044 i_rd_done in the same cycle as word 1583 into the other bank -> next cycle o_rd_bank toggles, o_rd_valid=1, both states are correct.
REQ-045 14 symbols with an immediate i_rd_done after each -> tags 0..13, then 0 again; zero overflows.
